// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing constants, sync bundle type and total-length helpers
package vga_timing_pkg;

    localparam int CNT_W = 10;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    // 640x480@60, 25 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int SYNC_DELAY_MAX = 7;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_bus_t;

    localparam int SYNC_BUS_W = $bits(sync_bus_t);

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total_default();
        return line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    endfunction

    function automatic int v_total_default();
        return line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// rtl/vga_timing_gen_delay_line.sv - vga_delay_line: width/depth shift register with sync reset value and enable
// DEPTH=0 degenerates to a wire so the syncs line up with X/Y.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, en_i};
        assign data_o      = data_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RESET_VAL;
                end
            end else if (en_i) begin
                stage_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator: X/Y, line/frame pulses, delayed HS/VS/BLANK_n
// Optional clock enable input iCE when VGA_TIMING_CE_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int   SYNC_DELAY = 3
) (
    input  logic             iVGA_CLK,
    input  logic             iRST,
`ifdef VGA_TIMING_CE_EN
    input  logic             iCE,
`endif
    output logic [CNT_W-1:0] oVGA_X,
    output logic [CNT_W-1:0] oVGA_Y,
    output logic             oHS,
    output logic             oVS,
    output logic             oBLANK_n,
    output logic             oLINE_START,
    output logic             oFRAME_START
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: line or frame total exceeds 10-bit counter range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > SYNC_DELAY_MAX) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..7");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bus_t SYNC_IDLE = '{hs: !SYNC_POL, vs: !SYNC_POL, blank_n: 1'b0};

    logic ce;
`ifdef VGA_TIMING_CE_EN
    assign ce = iCE;
`else
    assign ce = 1'b1;
`endif

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Output stage: X/Y, pulses and the undelayed sync bundle share one register stage
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    sync_bus_t        sync_q, sync_d;
    logic             h_act, v_act, h_in_sync, v_in_sync;

    always_comb begin
        h_act         = (h_cnt_q < H_ACT);
        v_act         = (v_cnt_q < V_ACT);
        h_in_sync     = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
        v_in_sync     = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        sync_d        = sync_q;
        if (ce) begin
            x_d            = h_act ? h_cnt_q : '0;
            y_d            = v_act ? v_cnt_q : '0;
            line_start_d   = (h_cnt_q == '0);
            frame_start_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
            sync_d.hs      = h_in_sync ? SYNC_POL : !SYNC_POL;
            sync_d.vs      = v_in_sync ? SYNC_POL : !SYNC_POL;
            sync_d.blank_n = h_act && v_act;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_q        <= SYNC_IDLE;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            sync_q        <= sync_d;
        end
    end

    logic [SYNC_BUS_W-1:0] sync_dly_raw;
    sync_bus_t             sync_dly;

    vga_delay_line #(
        .WIDTH     (SYNC_BUS_W),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (SYNC_BUS_W'(SYNC_IDLE))
    ) u_sync_dly (
        .clk_i  (iVGA_CLK),
        .rst_i  (iRST),
        .en_i   (ce),
        .data_i (sync_q),
        .data_o (sync_dly_raw)
    );

    assign sync_dly = sync_bus_t'(sync_dly_raw);

    assign oVGA_X   = x_q;
    assign oVGA_Y   = y_q;
    assign oHS      = sync_dly.hs;
    assign oVS      = sync_dly.vs;
    assign oBLANK_n = sync_dly.blank_n;
    // Pulse registers hold across disabled cycles; gating with ce keeps each event one clock wide
    assign oLINE_START  = line_start_q & ce;
    assign oFRAME_START = frame_start_q & ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench: default timing (delay 3) and a tiny raster (delay 0)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_hs, d_vs, d_b, d_ls, d_fs;
    logic       s_hs, s_vs, s_b, s_ls, s_fs;

    vga_timing_gen dut_def (
        .iVGA_CLK     (clk),
        .iRST         (rst),
        .oVGA_X       (d_x),
        .oVGA_Y       (d_y),
        .oHS          (d_hs),
        .oVS          (d_vs),
        .oBLANK_n     (d_b),
        .oLINE_START  (d_ls),
        .oFRAME_START (d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b0), .SYNC_DELAY (0)
    ) dut_s0 (
        .iVGA_CLK     (clk),
        .iRST         (rst),
        .oVGA_X       (s_x),
        .oVGA_Y       (s_y),
        .oHS          (s_hs),
        .oVS          (s_vs),
        .oBLANK_n     (s_b),
        .oLINE_START  (s_ls),
        .oFRAME_START (s_fs)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int h, v, hd, hh;
        int ex, ey, eb, ehs, evs, els, efs;
        int e_dx, e_dy, e_db, e_dhs, e_dvs, e_dls, e_dfs;
        int e_sx, e_sy, e_sb, e_shs, e_svs, e_sls, e_sfs;
        int n_db, n_dhs, n_dls, n_dfs, n_sls, n_sfs, n_svs;
        e_dx = 0; e_dy = 0; e_db = 0; e_dhs = 0; e_dvs = 0; e_dls = 0; e_dfs = 0;
        e_sx = 0; e_sy = 0; e_sb = 0; e_shs = 0; e_svs = 0; e_sls = 0; e_sfs = 0;
        n_db = 0; n_dhs = 0; n_dls = 0; n_dfs = 0; n_sls = 0; n_sfs = 0; n_svs = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_hs", d_hs, 1);
        check("rst_vs", d_vs, 1);
        check("rst_blank", d_b, 0);
        check("rst_line_start", d_ls, 0);
        check("rst_frame_start", d_fs, 0);
        check("rst_s0_hs", s_hs, 1);

        rst = 1'b0;
        // sample k is taken after the k-th edge since release; it reflects counter value k-1
        for (int k = 1; k <= 1900; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_frame_start", d_fs, 1);
                check("first_line_start", d_ls, 1);
                check("first_s0_frame_start", s_fs, 1);
            end
            h  = (k - 1) % 800;
            v  = (k - 1) / 800;
            ex = (h < 640) ? h : 0;
            ey = v;
            els = (h == 0) ? 1 : 0;
            efs = (k == 1) ? 1 : 0;
            hd = k - 4;
            if (hd < 0) begin
                eb = 0; ehs = 1;
            end else begin
                hh  = hd % 800;
                eb  = (hh < 640) ? 1 : 0;
                ehs = (hh >= 656 && hh < 752) ? 0 : 1;
            end
            if (d_x !== 10'(ex)) e_dx++;
            if (d_y !== 10'(ey)) e_dy++;
            if (d_b !== 1'(eb)) e_db++;
            if (d_hs !== 1'(ehs)) e_dhs++;
            if (d_vs !== 1'b1) e_dvs++;
            if (d_ls !== 1'(els)) e_dls++;
            if (d_fs !== 1'(efs)) e_dfs++;
            if (d_b === 1'b1) n_db++;
            if (d_hs === 1'b0) n_dhs++;
            if (d_ls === 1'b1) n_dls++;
            if (d_fs === 1'b1) n_dfs++;

            h   = (k - 1) % 14;
            v   = ((k - 1) / 14) % 7;
            ex  = (h < 8) ? h : 0;
            ey  = (v < 4) ? v : 0;
            eb  = (h < 8 && v < 4) ? 1 : 0;
            ehs = (h >= 10 && h < 12) ? 0 : 1;
            evs = (v == 5) ? 0 : 1;
            els = (h == 0) ? 1 : 0;
            efs = (h == 0 && v == 0) ? 1 : 0;
            if (s_x !== 10'(ex)) e_sx++;
            if (s_y !== 10'(ey)) e_sy++;
            if (s_b !== 1'(eb)) e_sb++;
            if (s_hs !== 1'(ehs)) e_shs++;
            if (s_vs !== 1'(evs)) e_svs++;
            if (s_ls !== 1'(els)) e_sls++;
            if (s_fs !== 1'(efs)) e_sfs++;
            if (s_ls === 1'b1) n_sls++;
            if (s_fs === 1'b1) n_sfs++;
            if (s_vs === 1'b0) n_svs++;
        end

        check("def_x_cycles_wrong", e_dx, 0);
        check("def_y_cycles_wrong", e_dy, 0);
        check("def_blank_cycles_wrong", e_db, 0);
        check("def_hs_cycles_wrong", e_dhs, 0);
        check("def_vs_cycles_wrong", e_dvs, 0);
        check("def_line_start_cycles_wrong", e_dls, 0);
        check("def_frame_start_cycles_wrong", e_dfs, 0);
        check("def_blank_high_total", n_db, 1577);
        check("def_hs_low_total", n_dhs, 192);
        check("def_line_start_total", n_dls, 3);
        check("def_frame_start_total", n_dfs, 1);
        check("s0_x_cycles_wrong", e_sx, 0);
        check("s0_y_cycles_wrong", e_sy, 0);
        check("s0_blank_cycles_wrong", e_sb, 0);
        check("s0_hs_cycles_wrong", e_shs, 0);
        check("s0_vs_cycles_wrong", e_svs, 0);
        check("s0_line_start_cycles_wrong", e_sls, 0);
        check("s0_frame_start_cycles_wrong", e_sfs, 0);
        check("s0_line_start_total", n_sls, 136);
        check("s0_frame_start_total", n_sfs, 20);
        check("s0_vs_low_total", n_svs, 266);

        // mid-frame reset: default counters sit at h=300, v=2 here
        check("pre_rst_x", d_x, 299);
        check("pre_rst_blank", d_b, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_x", d_x, 0);
        check("midrst_y", d_y, 0);
        check("midrst_blank", d_b, 0);
        check("midrst_line_start", d_ls, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_x", d_x, 0);
        check("post_rst_y", d_y, 0);
        check("post_rst_frame_start", d_fs, 1);
        check("post_rst_line_start", d_ls, 1);
        check("post_rst_s0_frame_start", s_fs, 1);
        check("post_rst_s0_blank", s_b, 1);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("flush_blank_%0d", c), d_b, 0);
            check($sformatf("flush_hs_%0d", c), d_hs, 1);
            check($sformatf("flush_vs_%0d", c), d_vs, 1);
        end
        @(negedge clk);
        check("after_flush_blank", d_b, 1);
        check("after_flush_x", d_x, 3);
        check("after_flush_frame_start", d_fs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator that sits directly upstream of the pixel colour stages (border/overlay generators) in the VGA display path. It produces the pixel coordinates consumed by those stages and the HS/VS/blank signals for the DAC. The syncs are pipelined so they stay aligned with the registered colour outputs of the downstream stage. Default timing is 640x480@60 with a 25 MHz pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active sync level (0 = active-low HS/VS)
SYNC_DELAY, 3, extra cycles on HS/VS/BLANK relative to X/Y; matches downstream colour latency; range 0..7

Ports:
iVGA_CLK  in  1  pixel clock
iRST  in  1  reset; synchronous, active-high, sampled on rising edge of iVGA_CLK
oVGA_X  out  10  pixel column, 0..H_ACTIVE-1 in active region, 0 in blanking
oVGA_Y  out  10  pixel row, 0..V_ACTIVE-1 in active lines, 0 in blanking
oHS  out  1  horizontal sync, level set by SYNC_POL, delayed by SYNC_DELAY
oVS  out  1  vertical sync, level set by SYNC_POL, delayed by SYNC_DELAY
oBLANK_n  out  1  1 = active video, delayed by SYNC_DELAY
oLINE_START  out  1  one-cycle pulse aligned with oVGA_X=0 of every line, undelayed
oFRAME_START  out  1  one-cycle pulse aligned with X=0,Y=0, undelayed

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both counters are 10 bits wide. Elaboration fails if either total exceeds 1024.
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 on the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical order is the same, using lines.
- Active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- oVGA_X, oVGA_Y, oLINE_START and oFRAME_START are registered with 1-cycle latency from the counters.
- oLINE_START fires on every line, including blanking lines.
- oHS, oVS and oBLANK_n are computed at the same stage as X/Y, then pass through a SYNC_DELAY-deep shift register.
- With SYNC_DELAY=0, the syncs are aligned with X/Y.
- Reset (iRST=1 at a clock edge), at any point including mid-frame:
  - h_cnt and v_cnt go to 0.
  - oVGA_X and oVGA_Y go to 0; oLINE_START and oFRAME_START go to 0.
  - oBLANK_n goes to 0; oHS and oVS go to the inactive level (!SYNC_POL).
  - Every delay-line stage is loaded with the inactive values.
- First cycle after reset deasserts: counters = (0,0). On the next edge the outputs show X=0, Y=0, oFRAME_START=1, oLINE_START=1.
- No handshake and no backpressure: the block free-runs.

Optional Feature:
- Macro: VGA_TIMING_CE_EN.
- Defined:
  - Adds input port iCE (1 bit), placed after iRST.
  - Counters, output registers and the delay line advance only on cycles where iCE=1; otherwise everything holds.
  - oLINE_START and oFRAME_START are gated with iCE so each event pulses for exactly one cycle.
  - Reset overrides iCE.
  - This allows operation from a 50 MHz clock with a divide-by-2 enable.
- Undefined: no iCE port; the block advances every cycle.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 timing constants;
  - SYNC_ACTIVE_LOW/HIGH constants;
  - total-length helper functions.
- Sub-module vga_delay_line: parameterised width/depth shift register with synchronous reset value and optional enable. It carries {HS,VS,BLANK_n}.

Test Plan:
- Release reset, run 2 frames (840000 cycles, defaults) -> per line:
  - X = 0..639 for 640 cycles, then 0 for 160 cycles;
  - oBLANK_n high for exactly 640 cycles per active line;
  - total of 307200 active cycles per frame.
- HS check (defaults, SYNC_DELAY=3) -> oHS low for 96 cycles, starting 3+1 cycles after the counter reaches h=656. VS is low during lines 490-491 only.
- Pulse check -> oFRAME_START pulses every 420000 cycles and oLINE_START every 800 cycles. The first of each appears 1 cycle after reset release with X=0, Y=0.
- Reset for 1 cycle at h=300, v=200 -> next output X=0, Y=0 with oFRAME_START=1. oHS/oVS are inactive and oBLANK_n=0 for 3 cycles (delay line flushed).
- SYNC_DELAY=0, H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> line = 14 cycles, frame = 98 cycles, oHS aligned with X output.
- VGA_TIMING_CE_EN defined, iCE toggling 1,0 -> line = 1600 clocks, each X value held 2 cycles, oLINE_START high for exactly 1 cycle per line.
